// File: rtl/md_defs.sv
// Shared encodings for the execute-stage multiply/divide unit.
package md_defs;

    // HILOOP operation codes
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_NONE  = 3'b111;

    // WHILO write-select codes
    localparam logic [1:0] W_HI   = 2'b00;
    localparam logic [1:0] W_LO   = 2'b01;
    localparam logic [1:0] W_NONE = 2'b11;

    // HILOSel read-select codes
    localparam logic [1:0] R_HI = 2'b00;
    localparam logic [1:0] R_LO = 2'b01;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_t;

    // Only the four arithmetic codes launch an operation; everything else is a no-op.
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
module md_compute
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor_u;
    logic [31:0] divisor_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot_m;
    logic [31:0] rem_m;

    // Signed and unsigned 64-bit products; sign extension is explicit.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};
    end

    // Division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        a_neg     = a[31];
        b_neg     = b[31];
        a_mag     = a_neg ? (~a + 32'd1) : a;
        b_mag     = b_neg ? (~b + 32'd1) : b;
        divisor_u = (b == 32'd0) ? 32'd1 : b;
        divisor_s = (b == 32'd0) ? 32'd1 : b_mag;
        quot_u    = a / divisor_u;
        rem_u     = a % divisor_u;
        quot_m    = a_mag / divisor_s;
        rem_m     = a_mag % divisor_s;
    end

    // Select result per op; remainder takes the dividend's sign, quotient truncates to zero.
    always_comb begin
        hi_next  = 32'd0;
        lo_next  = 32'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT: begin
                hi_next = prod_s[63:32];
                lo_next = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_next = prod_u[63:32];
                lo_next = prod_u[31:0];
            end
            MD_DIV: begin
                div_zero = (b == 32'd0);
                lo_next  = (a_neg ^ b_neg) ? (~quot_m + 32'd1) : quot_m;
                hi_next  = a_neg ? (~rem_m + 32'd1) : rem_m;
            end
            MD_DIVU: begin
                div_zero = (b == 32'd0);
                lo_next  = quot_u;
                hi_next  = rem_u;
            end
            default: begin
                hi_next  = 32'd0;
                lo_next  = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: fixed-latency FSM, operand latches and HI/LO registers.
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  hilo_op,
    input  logic [1:0]  whilo,
    input  logic [1:0]  hilo_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hilo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      hi_next;
    logic [31:0]      lo_next;
    logic             div_zero;

    md_compute u_compute (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi_next  (hi_next),
        .lo_next  (lo_next),
        .div_zero (div_zero)
    );

    // FSM, latency counter, operand latches and HI/LO update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= MD_NONE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_valid_op(hilo_op)) begin
                        op_q  <= hilo_op;
                        a_q   <= rs_data;
                        b_q   <= rt_data;
                        cnt   <= is_div_op(hilo_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else if (!start) begin
                        if (whilo == W_HI) begin
                            hi <= rs_data;
                        end else if (whilo == W_LO) begin
                            lo <= rs_data;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (!div_zero) begin
                            hi <= hi_next;
                            lo <= lo_next;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Unbypassed read port of the architectural HI/LO registers.
    always_comb begin
        case (hilo_sel)
            R_HI:    hilo_out = hi;
            R_LO:    hilo_out = lo;
            default: hilo_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_mult_div_unit;
    import md_defs::*;

    localparam int unsigned N_MULT = 5;
    localparam int unsigned N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  hilo_op;
    logic [1:0]  whilo;
    logic [1:0]  hilo_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hilo_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hilo_op  (hilo_op),
        .whilo    (whilo),
        .hilo_sel (hilo_sel),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .hilo_out (hilo_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    // Architectural result of one operation, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr, sp;
        longint unsigned ua, ub, uq, ur, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT: begin
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MD_DIV: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            MD_DIVU: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                m_lo = uq[31:0];
                m_hi = ur[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic read_check(input string name);
        hilo_sel = R_HI; #1;
        check({name, "_hi"}, hilo_out, m_hi);
        hilo_sel = R_LO; #1;
        check({name, "_lo"}, hilo_out, m_lo);
    endtask

    // Launch an op, optionally poke a second start 2 cycles in, and measure busy length.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit extra_start);
        int cycles;
        int expn;
        expn = (op == MD_DIV || op == MD_DIVU) ? N_DIV : N_MULT;
        start = 1'b1; hilo_op = op; rs_data = a; rt_data = b; whilo = W_NONE;
        tick();
        start = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (extra_start && cycles == 2) begin
                start = 1'b1; hilo_op = MD_MULT; rs_data = 32'd12345; rt_data = 32'd777;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 32'(cycles), 32'(expn));
        model(op, a, b);
        read_check(name);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; hilo_op = MD_NONE; whilo = W_NONE;
        hilo_sel = R_HI; rs_data = 32'd0; rt_data = 32'd0;
        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        read_check("reset");
        reset = 1'b0;
        tick();

        // mult -2 * 3
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg_hi_const", m_hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", m_lo, 32'hFFFF_FFFA);

        // div -7 / 2 and divu 7 / 2
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b0);

        // overflow corner
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // preload and divide by zero
        whilo = W_HI; rs_data = 32'h11; tick();
        whilo = W_LO; rs_data = 32'h22; tick();
        whilo = W_NONE;
        m_hi = 32'h11; m_lo = 32'h22;
        read_check("preload");
        run_op("divu_zero", MD_DIVU, 32'd99, 32'd0, 1'b0);
        run_op("div_zero", MD_DIV, 32'hFFFF_0000, 32'd0, 1'b0);

        // multu max with a second start during RUN
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu_busy_after", {31'd0, busy}, 32'd0);

        // mtlo with start low
        whilo = W_LO; rs_data = 32'hDEAD_BEEF; tick();
        whilo = W_NONE;
        m_lo = 32'hDEAD_BEEF;
        read_check("mtlo");

        // mtlo collides with start: start wins, old LO visible during RUN
        start = 1'b1; hilo_op = MD_MULT; whilo = W_LO; rs_data = 32'd2; rt_data = 32'd3;
        tick();
        start = 1'b0; whilo = W_NONE;
        check("collide_busy", {31'd0, busy}, 32'd1);
        hilo_sel = R_LO; #1;
        check("collide_lo_during_run", hilo_out, 32'hDEAD_BEEF);
        for (int i = 0; i < int'(N_MULT); i++) tick();
        model(MD_MULT, 32'd2, 32'd3);
        read_check("collide");

        // undefined / none op: no launch
        start = 1'b1; hilo_op = 3'b101; rs_data = 32'd5; rt_data = 32'd5; tick();
        start = 1'b0;
        check("undef_op_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; hilo_op = MD_NONE; tick();
        start = 1'b0;
        check("none_op_busy", {31'd0, busy}, 32'd0);
        read_check("noop");

        // randomized ops and moves
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                whilo = $urandom_range(0, 1) ? W_HI : W_LO;
                rs_data = $urandom;
                if (whilo == W_HI) m_hi = rs_data; else m_lo = rs_data;
                tick();
                whilo = W_NONE;
            end
            run_op($sformatf("rand%0d", k), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a div
        whilo = W_HI; rs_data = 32'h5555; tick(); whilo = W_NONE;
        start = 1'b1; hilo_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7; tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        read_check("async_rst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        read_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit. Consumes the start / HILOOP / WHILO / HILOSel_E controls from the E-stage controller and owns the HI/LO registers.
- Computes mult, multu, div and divu over a fixed multi-cycle latency. Exposes busy so the hazard unit can stall md-class instructions.
- Services mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (minimum 1).
- DIV_CYCLES, 10, busy cycles for div/divu (minimum 1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to launch the operation selected by hilo_op.
- hilo_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 111 none; other codes are treated as none.
- whilo  input  2  00 mthi, 01 mtlo, 11 none.
- hilo_sel  input  2  00 read HI, 01 read LO, 11 read 0.
- rs_data  input  32  forwarded rs operand: multiplicand/dividend, or the mthi/mtlo source.
- rt_data  input  32  forwarded rt operand: multiplier/divisor.
- busy  output  1  operation in flight.
- hilo_out  output  32  combinational read of HI/LO per hilo_sel.

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0. Any in-flight operation and its latched operands are discarded, and no commit happens after reset releases.
- States: IDLE, RUN. busy=1 exactly in RUN.
- IDLE + start with a valid hilo_op, sampled at edge T:
  - rs_data, rt_data and hilo_op are latched at edge T.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy is high for exactly N cycles, from after edge T up to edge T+N.
- RUN: counter decrements each edge. On the edge where the counter reaches 0, HI/LO are committed and the unit returns to IDLE, so busy falls that same edge.
- IDLE + start with hilo_op=111 or an undefined code: no action.
- mult: signed 32x32 -> 64; HI=product[63:32], LO=product[31:0]. multu: same, unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu: unsigned.
- Divisor 0 (div or divu): full latency still runs; HI/LO are left unchanged at commit.
- mthi/mtlo: when not busy and start=0, HI or LO is written with rs_data at the edge, taking effect next cycle.
  - While busy, writes are ignored; the hazard unit guarantees none arrive.
  - start=1 in the same cycle: start wins and the write is ignored.
- start while busy: ignored. The current operation is unaffected; busy does not extend and operands are not re-latched.
- hilo_out has no pipeline delay and reflects register contents only:
  - during RUN, the old HI/LO is visible;
  - a same-edge mthi write is not bypassed.
- All arithmetic is computed from the latched operands, so input changes during RUN have no effect.

Decomposition:
- Shared package md_defs holds:
  - HILOOP codes: MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_NONE=3'b111;
  - WHILO codes: W_HI=2'b00, W_LO=2'b01, W_NONE=2'b11;
  - HILOSel codes: R_HI=2'b00, R_LO=2'b01.
- Default latencies are set by the parameters above.
- One sub-module, md_compute: purely combinational. It maps latched operands and op to {hi_next, lo_next, div_zero}.
- The top level holds the FSM, counter, operand latches and HI/LO registers.

Test Plan:
- mult: rs=0xFFFFFFFE (-2), rt=3, start at edge 0 -> busy=1 during cycles 1..5, low after edge 5. Then hilo_sel=00 gives 0xFFFFFFFF and hilo_sel=01 gives 0xFFFFFFFA.
- div: rs=-7, rt=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu: rs=7, rt=2 -> LO=3, HI=1.
- divu by zero with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- multu: rs=rt=0xFFFFFFFF, start again 2 cycles later with different operands -> second start ignored; busy is still exactly 5 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- mtlo rs=0xDEADBEEF issued with start=0 -> next cycle hilo_out(sel=01)=0xDEADBEEF. Same mtlo issued with start=1 (mult 2x3) -> LO=6 after commit and the mtlo is lost.
- reset asserted at cycle 3 of a div -> busy=0 and HI=LO=0 immediately (asynchronous). After release, 20 idle cycles -> no commit and HI=LO=0.
